spi_host_seq: RTL and testbench

Host-side transaction sequencer sitting directly upstream of the SPI control unit. It buffers host bytes in a TX FIFO, hands each byte to the SPI datapath with a one-cycle `StartTx`, and waits for the control unit's `EndTx`. It then captures the received byte into an RX FIFO for the host. Back-to-back bytes are chained automatically while the TX FIFO is non-empty.

---
 rtl/spi_host_seq.sv | 126 ++++++++++++
 tb/tb_spi_host_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_seq.sv
// Host-side SPI sequencer: TX/RX byte FIFOs around a START/WAIT/CAPTURE handshake FSM.
// Define SPI_SEQ_CS_EN to add the CS_SETUP state and a real slave-select on CS_n.
module spi_host_seq #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       WrEn,
   input  logic [7:0] WrData,
   output logic       TxFull,
   input  logic       RdEn,
   output logic [7:0] RdData,
   output logic       RxEmpty,
   output logic       RxOvf,
   input  logic       ClrOvf,
   output logic       Busy,
   output logic       StartTx,
   output logic [7:0] TxData,
   input  logic       EndTx,
   input  logic [7:0] RxData,
   output logic       CS_n
);

`ifdef SPI_SEQ_CS_EN
   typedef enum logic [2:0] {IDLE, CS_SETUP, START, WAIT, CAPTURE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE} state_t;
`endif

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   state_t         state, state_nxt;
   logic [7:0]     tx_mem [DEPTH];
   logic [7:0]     rx_mem [DEPTH];
   logic [AW-1:0]  tx_wp, tx_rp, rx_wp, rx_rp;
   logic [AW:0]    tx_cnt, rx_cnt;
   logic [7:0]     rx_byte;
   logic           tx_empty, rx_full;
   logic           tx_push, tx_pop, rx_push, rx_pop;

   assign tx_empty = (tx_cnt == '0);
   assign TxFull   = (tx_cnt == FULL);
   assign rx_full  = (rx_cnt == FULL);
   assign RxEmpty  = (rx_cnt == '0);
   assign RdData   = rx_mem[rx_rp];
   assign Busy     = (state != IDLE);

   // The TX head is consumed on the edge that enters START, together with the TxData load.
   assign tx_push = WrEn && !TxFull;
   assign tx_pop  = (state_nxt == START);
   assign rx_push = (state == CAPTURE) && !rx_full;
   assign rx_pop  = RdEn && !RxEmpty;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
`ifdef SPI_SEQ_CS_EN
            if (!tx_empty) state_nxt = CS_SETUP;
         CS_SETUP: state_nxt = START;
`else
            if (!tx_empty) state_nxt = START;
`endif
         START:    state_nxt = WAIT;
         WAIT:     if (EndTx) state_nxt = CAPTURE;
         CAPTURE:  state_nxt = tx_empty ? IDLE : START;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state   <= IDLE;
         StartTx <= 1'b0;
         TxData  <= 8'h00;
         rx_byte <= 8'h00;
         RxOvf   <= 1'b0;
      end else begin
         state   <= state_nxt;
         StartTx <= (state_nxt == START);
         if (state_nxt == START) TxData <= tx_mem[tx_rp];
         if (state == WAIT && EndTx) rx_byte <= RxData;
         // A drop in the same cycle as ClrOvf must leave the flag set.
         if (state == CAPTURE && rx_full) RxOvf <= 1'b1;
         else if (ClrOvf)                 RxOvf <= 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
         else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
         else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (tx_push) tx_mem[tx_wp] <= WrData;
      if (rx_push) rx_mem[rx_wp] <= rx_byte;
   end

`ifdef SPI_SEQ_CS_EN
   logic cs_q;
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) cs_q <= 1'b1;
      else     cs_q <= (state_nxt == IDLE);
   end
   assign CS_n = cs_q;
`else
   assign CS_n = 1'b0;
`endif

endmodule

// File: tb/tb_spi_host_seq.sv
// Directed self-checking bench for spi_host_seq; the bench plays the host and the SPI control unit.
// Expectations for CS_n and first-byte latency follow SPI_SEQ_CS_EN when it is defined.
module tb_spi_host_seq;

`ifdef SPI_SEQ_CS_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif
   localparam logic CS_IDLE = CS_EN ? 1'b1 : 1'b0;

   logic       Clk = 1'b0;
   logic       Rst, WrEn, RdEn, ClrOvf, EndTx;
   logic [7:0] WrData, RxData;
   logic       TxFull, RxEmpty, RxOvf, Busy, StartTx, CS_n;
   logic [7:0] RdData, TxData;

   int total  = 0;
   int passed = 0;

   spi_host_seq #(.DEPTH(4), .AW(2)) dut (
      .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrData(WrData), .TxFull(TxFull),
      .RdEn(RdEn), .RdData(RdData), .RxEmpty(RxEmpty), .RxOvf(RxOvf), .ClrOvf(ClrOvf),
      .Busy(Busy), .StartTx(StartTx), .TxData(TxData), .EndTx(EndTx), .RxData(RxData),
      .CS_n(CS_n)
   );

   always #5 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Waits (bounded) for the StartTx pulse, records TxData, and steps into WAIT.
   task automatic begin_xfer(output bit ok, output logic [7:0] txd);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (StartTx === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      txd = TxData;
      tick();
   endtask

   // From WAIT: optional host read, then EndTx with rxb; returns one cycle after CAPTURE.
   task automatic finish_xfer(input bit rd, input logic [7:0] rxb);
      if (rd && RxEmpty === 1'b0) RdEn = 1'b1;
      tick();
      RdEn = 1'b0;
      EndTx = 1'b1; RxData = rxb;
      tick();
      EndTx = 1'b0; RxData = 8'h00;
      tick();
   endtask

   task automatic write_byte(input logic [7:0] d);
      WrData = d; WrEn = 1'b1;
      tick();
      WrEn = 1'b0;
   endtask

   task automatic test_reset;
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      total++; if (StartTx !== 1'b0) $display("FAIL reset_starttx: got %b want 0", StartTx); else passed++;
      total++; if (TxData !== 8'h00) $display("FAIL reset_txdata: got %h want 00", TxData); else passed++;
      total++; if (CS_n !== CS_IDLE) $display("FAIL reset_csn: got %b want %b", CS_n, CS_IDLE); else passed++;
      total++; if ({Busy, TxFull, RxEmpty, RxOvf} !== 4'b0010)
         $display("FAIL reset_flags: got busy/full/empty/ovf %b want 0010", {Busy, TxFull, RxEmpty, RxOvf}); else passed++;
      Rst = 1'b0;
      tick();
      total++; if (Busy !== 1'b0) $display("FAIL reset_idle: got busy %b want 0", Busy); else passed++;
   endtask

   task automatic test_single;
      write_byte(8'hA5);
      total++; if ({Busy, StartTx} !== 2'b00) $display("FAIL single_n: got busy/start %b want 00", {Busy, StartTx}); else passed++;
      if (CS_EN) begin
         tick();
         total++; if ({CS_n, StartTx, Busy} !== 3'b001)
            $display("FAIL single_cs_setup: got csn/start/busy %b want 001", {CS_n, StartTx, Busy}); else passed++;
      end
      tick();
      total++; if (StartTx !== 1'b1) $display("FAIL single_start: got %b want 1", StartTx); else passed++;
      total++; if (TxData !== 8'hA5) $display("FAIL single_txdata: got %h want a5", TxData); else passed++;
      total++; if (CS_n !== 1'b0) $display("FAIL single_csn_low: got %b want 0", CS_n); else passed++;
      tick();
      total++; if (StartTx !== 1'b0) $display("FAIL single_pulse: got %b want 0", StartTx); else passed++;
      repeat (18) tick();
      EndTx = 1'b1; RxData = 8'h3C;
      tick();
      EndTx = 1'b0; RxData = 8'h00;
      total++; if (RxEmpty !== 1'b1) $display("FAIL single_capture_empty: got %b want 1", RxEmpty); else passed++;
      tick();
      total++; if (RxEmpty !== 1'b0) $display("FAIL single_rx_empty: got %b want 0", RxEmpty); else passed++;
      total++; if (RdData !== 8'h3C) $display("FAIL single_rddata: got %h want 3c", RdData); else passed++;
      total++; if ({Busy, StartTx, CS_n} !== {2'b00, CS_IDLE})
         $display("FAIL single_done: got busy/start/csn %b want %b", {Busy, StartTx, CS_n}, {2'b00, CS_IDLE}); else passed++;
      RdEn = 1'b1;
      tick();
      RdEn = 1'b0;
      total++; if (RxEmpty !== 1'b1) $display("FAIL single_read: got empty %b want 1", RxEmpty); else passed++;
   endtask

   task automatic test_burst;
      bit ok;
      logic [7:0] txd;
      write_byte(8'h01);
      begin_xfer(ok, txd);
      total++; if (!ok || txd !== 8'h01) $display("FAIL burst_first: got ok %b tx %h want 1 01", ok, txd); else passed++;
      for (int j = 0; j < 3; j++) write_byte(8'(j + 2));
      for (int i = 0; i < 4; i++) begin
         tick();
         EndTx = 1'b1; RxData = 8'(8'hC0 + i);
         tick();
         EndTx = 1'b0; RxData = 8'h00;
         tick();
         if (i < 3) begin
            total++; if ({StartTx, CS_n} !== 2'b10 || TxData !== 8'(i + 2))
               $display("FAIL burst_chain%0d: got start/csn %b tx %h want 10 %h", i, {StartTx, CS_n}, TxData, 8'(i + 2));
            else passed++;
            tick();
         end else begin
            total++; if ({Busy, CS_n} !== {1'b0, CS_IDLE})
               $display("FAIL burst_end: got busy/csn %b want %b", {Busy, CS_n}, {1'b0, CS_IDLE}); else passed++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         total++; if (RdData !== 8'(8'hC0 + i)) $display("FAIL burst_rx%0d: got %h want %h", i, RdData, 8'(8'hC0 + i)); else passed++;
         RdEn = 1'b1;
         tick();
         RdEn = 1'b0;
      end
      total++; if (RxEmpty !== 1'b1) $display("FAIL burst_drained: got %b want 1", RxEmpty); else passed++;
   endtask

   task automatic test_tx_overflow;
      bit ok;
      logic [7:0] txd;
      write_byte(8'h11);
      begin_xfer(ok, txd);
      total++; if (!ok || txd !== 8'h11) $display("FAIL txovf_first: got ok %b tx %h want 1 11", ok, txd); else passed++;
      for (int j = 0; j < 4; j++) begin
         write_byte(8'(8'h22 + 8'h11 * j));
         total++; if (TxFull !== (j == 3)) $display("FAIL txovf_full%0d: got %b want %b", j, TxFull, (j == 3)); else passed++;
      end
      write_byte(8'h66);
      total++; if (TxFull !== 1'b1) $display("FAIL txovf_drop_full: got %b want 1", TxFull); else passed++;
      EndTx = 1'b1; RxData = 8'h81;
      tick();
      EndTx = 1'b0; RxData = 8'h00;
      total++; if (TxFull !== 1'b1) $display("FAIL txovf_capture_full: got %b want 1", TxFull); else passed++;
      tick();
      total++; if ({TxFull, StartTx} !== 2'b01 || TxData !== 8'h22)
         $display("FAIL txovf_pop: got full/start %b tx %h want 01 22", {TxFull, StartTx}, TxData); else passed++;
      for (int j = 0; j < 4; j++) begin
         begin_xfer(ok, txd);
         total++; if (!ok || txd !== 8'(8'h22 + 8'h11 * j))
            $display("FAIL txovf_byte%0d: got ok %b tx %h want 1 %h", j, ok, txd, 8'(8'h22 + 8'h11 * j)); else passed++;
         finish_xfer(1'b1, 8'(8'h82 + j));
      end
      total++; if ({Busy, TxFull, RxOvf} !== 3'b000)
         $display("FAIL txovf_fifth_dropped: got busy/full/ovf %b want 000", {Busy, TxFull, RxOvf}); else passed++;
      total++; if (RdData !== 8'h85) $display("FAIL txovf_last_rx: got %h want 85", RdData); else passed++;
      RdEn = 1'b1;
      tick();
      RdEn = 1'b0;
   endtask

   task automatic test_rx_overflow;
      bit ok;
      logic [7:0] txd;
      write_byte(8'hB1);
      begin_xfer(ok, txd);
      total++; if (!ok || txd !== 8'hB1) $display("FAIL rxovf_first: got ok %b tx %h want 1 b1", ok, txd); else passed++;
      for (int j = 0; j < 4; j++) write_byte(8'(8'hB2 + j));
      finish_xfer(1'b0, 8'hD1);
      for (int k = 0; k < 4; k++) begin
         begin_xfer(ok, txd);
         total++; if (!ok || txd !== 8'(8'hB2 + k)) $display("FAIL rxovf_tx%0d: got ok %b tx %h want 1 %h", k, ok, txd, 8'(8'hB2 + k)); else passed++;
         finish_xfer(1'b0, 8'(8'hD2 + k));
         if (k == 2) begin
            total++; if (RxOvf !== 1'b0) $display("FAIL rxovf_not_yet: got %b want 0", RxOvf); else passed++;
         end
      end
      total++; if ({RxOvf, Busy, RxEmpty} !== 3'b100)
         $display("FAIL rxovf_set: got ovf/busy/empty %b want 100", {RxOvf, Busy, RxEmpty}); else passed++;
      ClrOvf = 1'b1;
      tick();
      ClrOvf = 1'b0;
      total++; if (RxOvf !== 1'b0) $display("FAIL rxovf_clear: got %b want 0", RxOvf); else passed++;
      write_byte(8'hE1);
      begin_xfer(ok, txd);
      EndTx = 1'b1; RxData = 8'hEE;
      tick();
      EndTx = 1'b0; RxData = 8'h00;
      ClrOvf = 1'b1; RdEn = 1'b1;
      tick();
      ClrOvf = 1'b0; RdEn = 1'b0;
      total++; if (RxOvf !== 1'b1) $display("FAIL rxovf_set_wins: got %b want 1", RxOvf); else passed++;
      for (int k = 0; k < 3; k++) begin
         total++; if (RdData !== 8'(8'hD2 + k)) $display("FAIL rxovf_rx%0d: got %h want %h", k, RdData, 8'(8'hD2 + k)); else passed++;
         RdEn = 1'b1;
         tick();
         RdEn = 1'b0;
      end
      RdEn = 1'b1;
      tick();
      RdEn = 1'b0;
      total++; if ({RxEmpty, RxOvf} !== 2'b11) $display("FAIL rxovf_empty_read: got empty/ovf %b want 11", {RxEmpty, RxOvf}); else passed++;
      ClrOvf = 1'b1;
      tick();
      ClrOvf = 1'b0;
   endtask

   task automatic test_reset_mid_wait;
      bit ok;
      logic [7:0] txd;
      write_byte(8'h77);
      begin_xfer(ok, txd);
      total++; if (!ok || txd !== 8'h77) $display("FAIL rstmid_start: got ok %b tx %h want 1 77", ok, txd); else passed++;
      Rst = 1'b1;
      #1;
      total++; if ({Busy, CS_n, RxEmpty, StartTx} !== {1'b0, CS_IDLE, 2'b10})
         $display("FAIL rstmid_async: got busy/csn/empty/start %b want %b", {Busy, CS_n, RxEmpty, StartTx}, {1'b0, CS_IDLE, 2'b10}); else passed++;
      total++; if (TxData !== 8'h00) $display("FAIL rstmid_txdata: got %h want 00", TxData); else passed++;
      tick();
      Rst = 1'b0;
      tick();
      EndTx = 1'b1; RxData = 8'h99;
      tick();
      EndTx = 1'b0; RxData = 8'h00;
      repeat (2) tick();
      total++; if ({Busy, RxEmpty, StartTx} !== 3'b010)
         $display("FAIL rstmid_endtx_ignored: got busy/empty/start %b want 010", {Busy, RxEmpty, StartTx}); else passed++;
   endtask

   initial begin
      Rst = 1'b1; WrEn = 1'b0; RdEn = 1'b0; ClrOvf = 1'b0; EndTx = 1'b0;
      WrData = 8'h00; RxData = 8'h00;
      test_reset();
      test_single();
      test_burst();
      test_tx_overflow();
      test_rx_overflow();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
